// File: rtl/tlb_assoc.sv
// Set-associative TLB: registered one-cycle lookup, dedicated fill port with
// invalid-first / round-robin replacement, single-cycle flush, saturating stats.
module tlb_assoc #(
  parameter int VA_WIDTH    = 32,
  parameter int OFFSET_BITS = 10,
  parameter int PPN_WIDTH   = 22,
  parameter int SET_BITS    = 2,
  parameter int WAYS        = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                     clk,
  input  logic                                     resetN,
  input  logic                                     lookupValid,
  input  logic [VA_WIDTH-1:0]                      virtAddrIn,
  input  logic                                     fillValid,
  input  logic [VA_WIDTH-1:0]                      fillVirtAddr,
  input  logic [PPN_WIDTH-1:0]                     fillPhysPage,
  input  logic                                     flush,
  output logic                                     lookupDone,
  output logic                                     hit,
  output logic [VA_WIDTH-OFFSET_BITS-1:0]          virtPageOut,
  output logic [PPN_WIDTH-1:0]                     physPageOut,
  output logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] hitWay,
  output logic [CNT_WIDTH-1:0]                     hitCount,
  output logic [CNT_WIDTH-1:0]                     missCount
);

  localparam int VPN_W = VA_WIDTH - OFFSET_BITS;
  localparam int SETS  = 1 << SET_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAY_W-1:0]     ptr_q   [SETS];
  logic [VPN_W-1:0]     vpn_q   [SETS][WAYS];
  logic [PPN_WIDTH-1:0] ppn_q   [SETS][WAYS];

  logic                 unused_offset;
  assign unused_offset = ^{virtAddrIn[OFFSET_BITS-1:0], fillVirtAddr[OFFSET_BITS-1:0]};

  // Lookup match against the state present before this edge's updates.
  logic [VPN_W-1:0]     lk_vpn;
  logic [SET_BITS-1:0]  lk_set;
  logic                 lk_hit;
  logic [WAY_W-1:0]     lk_way;
  logic [PPN_WIDTH-1:0] lk_ppn;

  assign lk_vpn = virtAddrIn[VA_WIDTH-1:OFFSET_BITS];
  assign lk_set = lk_vpn[SET_BITS-1:0];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    lk_ppn = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && vpn_q[lk_set][w] == lk_vpn) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_ppn = ppn_q[lk_set][w];
      end
    end
  end

  // Fill victim selection: resident match, else lowest invalid, else pointer.
  logic [VPN_W-1:0]    fl_vpn;
  logic [SET_BITS-1:0] fl_set;
  logic                fl_match;
  logic [WAY_W-1:0]    fl_match_way;
  logic                fl_has_inv;
  logic [WAY_W-1:0]    fl_inv_way;
  logic [WAY_W-1:0]    fl_way;
  logic                fl_advance;

  assign fl_vpn = fillVirtAddr[VA_WIDTH-1:OFFSET_BITS];
  assign fl_set = fl_vpn[SET_BITS-1:0];

  always_comb begin
    fl_match     = 1'b0;
    fl_match_way = '0;
    fl_has_inv   = 1'b0;
    fl_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[fl_set][w] && vpn_q[fl_set][w] == fl_vpn) begin
        fl_match     = 1'b1;
        fl_match_way = WAY_W'(w);
      end
      if (!valid_q[fl_set][w]) begin
        fl_has_inv = 1'b1;
        fl_inv_way = WAY_W'(w);
      end
    end
    fl_advance = 1'b0;
    if (fl_match)        fl_way = fl_match_way;
    else if (fl_has_inv) fl_way = fl_inv_way;
    else begin
      fl_way     = ptr_q[fl_set];
      fl_advance = 1'b1;
    end
  end

  wire fill_en = fillValid && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the statements are written in.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill_en) begin
      valid_q[fl_set][fl_way] <= 1'b1;
      if (fl_advance)
        ptr_q[fl_set] <= (fl_way == WAY_W'(WAYS - 1)) ? '0 : fl_way + WAY_W'(1);
    end
  end

  // NOTE: tag/PPN storage has no reset; the valid bits alone qualify it, which
  // keeps the arrays mappable onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_q[fl_set][fl_way] <= fl_vpn;
      ppn_q[fl_set][fl_way] <= fillPhysPage;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lookupDone  <= 1'b0;
      hit         <= 1'b0;
      virtPageOut <= '0;
      physPageOut <= '0;
      hitWay      <= '0;
      hitCount    <= '0;
      missCount   <= '0;
    end else begin
      lookupDone <= lookupValid;
      if (lookupValid) begin
        hit         <= lk_hit && !flush;
        virtPageOut <= lk_vpn;
        physPageOut <= (lk_hit && !flush) ? lk_ppn : '0;
        hitWay      <= (lk_hit && !flush) ? lk_way : '0;
        if (lk_hit && !flush) begin
          if (hitCount != '1) hitCount <= hitCount + CNT_WIDTH'(1);
        end else begin
          if (missCount != '1) missCount <= missCount + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed self-checking bench for tlb_assoc with hand-computed expectations.
module tb_tlb_assoc;

  logic        clk = 1'b0;
  logic        resetN;
  logic        lookupValid;
  logic [31:0] virtAddrIn;
  logic        fillValid;
  logic [31:0] fillVirtAddr;
  logic [21:0] fillPhysPage;
  logic        flush;
  logic        lookupDone;
  logic        hit;
  logic [21:0] virtPageOut;
  logic [21:0] physPageOut;
  logic [0:0]  hitWay;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  int checks = 0;
  int errors = 0;

  tlb_assoc dut (
    .clk          (clk),
    .resetN       (resetN),
    .lookupValid  (lookupValid),
    .virtAddrIn   (virtAddrIn),
    .fillValid    (fillValid),
    .fillVirtAddr (fillVirtAddr),
    .fillPhysPage (fillPhysPage),
    .flush        (flush),
    .lookupDone   (lookupDone),
    .hit          (hit),
    .virtPageOut  (virtPageOut),
    .physPageOut  (physPageOut),
    .hitWay       (hitWay),
    .hitCount     (hitCount),
    .missCount    (missCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] a);
    lookupValid = 1'b1;
    virtAddrIn  = a;
    tick();
    lookupValid = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [21:0] p);
    fillValid    = 1'b1;
    fillVirtAddr = a;
    fillPhysPage = p;
    tick();
    fillValid = 1'b0;
  endtask

  task automatic expect_lk(input string tag, input logic h, input logic [21:0] vpn,
                           input logic [21:0] ppn, input logic w);
    check({tag, ".done"}, 32'(lookupDone), 32'd1);
    check({tag, ".hit"},  32'(hit), 32'(h));
    check({tag, ".vpn"},  32'(virtPageOut), 32'(vpn));
    check({tag, ".ppn"},  32'(physPageOut), 32'(ppn));
    check({tag, ".way"},  32'(hitWay), 32'(w));
  endtask

  task automatic expect_cnt(input string tag, input logic [15:0] h, input logic [15:0] m);
    check({tag, ".hitCount"},  32'(hitCount), 32'(h));
    check({tag, ".missCount"}, 32'(missCount), 32'(m));
  endtask

  initial begin
    resetN = 1'b0; lookupValid = 1'b0; virtAddrIn = '0;
    fillValid = 1'b0; fillVirtAddr = '0; fillPhysPage = '0; flush = 1'b0;
    tick(); tick();
    check("rst.done", 32'(lookupDone), 32'd0);
    check("rst.hit",  32'(hit), 32'd0);
    check("rst.vpn",  32'(virtPageOut), 32'd0);
    check("rst.ppn",  32'(physPageOut), 32'd0);
    expect_cnt("rst", 16'd0, 16'd0);
    resetN = 1'b1;
    tick();

    // Cold miss in set 1, then results hold while idle.
    lookup(32'h0000_1400);
    expect_lk("cold", 1'b0, 22'h5, 22'h0, 1'b0);
    expect_cnt("cold", 16'd0, 16'd1);
    tick();
    check("idle.done", 32'(lookupDone), 32'd0);
    check("idle.vpn",  32'(virtPageOut), 32'h5);

    // Fill then hit on a different offset in the same page.
    fill(32'h0000_1400, 22'h3A);
    lookup(32'h0000_17FF);
    expect_lk("fill1", 1'b1, 22'h5, 22'h3A, 1'b0);
    expect_cnt("fill1", 16'd1, 16'd1);
    tick();
    check("hold.hit", 32'(hit), 32'd1);
    check("hold.ppn", 32'(physPageOut), 32'h3A);

    // Set 1 replacement: 0x5 overwritten in way0, 0x9 to way1, 0xD evicts way0.
    fill(32'h0000_1400, 22'h10);
    fill(32'h0000_2400, 22'h20);
    fill(32'h0000_3400, 22'h30);
    lookup(32'h0000_1400);
    expect_lk("rr.5", 1'b0, 22'h5, 22'h0, 1'b0);
    lookup(32'h0000_2400);
    expect_lk("rr.9", 1'b1, 22'h9, 22'h20, 1'b1);
    lookup(32'h0000_3400);
    expect_lk("rr.D", 1'b1, 22'hD, 22'h30, 1'b0);
    expect_cnt("rr", 16'd3, 16'd2);

    // Refill resident 0x9: overwrite way1, pointer stays at 1.
    fill(32'h0000_2400, 22'h77);
    lookup(32'h0000_2400);
    expect_lk("refill", 1'b1, 22'h9, 22'h77, 1'b1);
    fill(32'h0000_4400, 22'h44);
    lookup(32'h0000_3400);
    expect_lk("ptr.D", 1'b1, 22'hD, 22'h30, 1'b0);
    lookup(32'h0000_4400);
    expect_lk("ptr.11", 1'b1, 22'h11, 22'h44, 1'b1);
    lookup(32'h0000_2400);
    expect_lk("evict9", 1'b0, 22'h9, 22'h0, 1'b0);
    expect_cnt("ptr", 16'd6, 16'd3);

    // Lookup and fill of the same page in one cycle: lookup sees old state.
    lookupValid = 1'b1; virtAddrIn = 32'h0000_5400;
    fillValid = 1'b1; fillVirtAddr = 32'h0000_5400; fillPhysPage = 22'h55;
    tick();
    lookupValid = 1'b0; fillValid = 1'b0;
    expect_lk("same", 1'b0, 22'h15, 22'h0, 1'b0);
    lookup(32'h0000_5400);
    expect_lk("after", 1'b1, 22'h15, 22'h55, 1'b0);

    // Other sets are independent.
    fill(32'h0000_0800, 22'h5);
    lookup(32'h0000_0800);
    expect_lk("set2", 1'b1, 22'h2, 22'h5, 1'b0);
    lookup(32'h0000_0C00);
    expect_lk("set3", 1'b0, 22'h3, 22'h0, 1'b0);
    expect_cnt("sets", 16'd8, 16'd5);

    // Flush with a resident lookup and a fill in the same cycle.
    lookupValid = 1'b1; virtAddrIn = 32'h0000_0800;
    fillValid = 1'b1; fillVirtAddr = 32'h0000_6000; fillPhysPage = 22'h99;
    flush = 1'b1;
    tick();
    lookupValid = 1'b0; fillValid = 1'b0; flush = 1'b0;
    expect_lk("flush", 1'b0, 22'h2, 22'h0, 1'b0);
    expect_cnt("flush", 16'd8, 16'd6);
    lookup(32'h0000_5400);
    expect_lk("fl.15", 1'b0, 22'h15, 22'h0, 1'b0);
    lookup(32'h0000_6000);
    expect_lk("fl.fill", 1'b0, 22'h18, 22'h0, 1'b0);
    lookup(32'h0000_0800);
    expect_lk("fl.2", 1'b0, 22'h2, 22'h0, 1'b0);
    expect_cnt("postfl", 16'd8, 16'd9);

    // Miss counter saturation.
    force dut.missCount = 16'hFFFF;
    #1;
    release dut.missCount;
    lookup(32'h0000_0C00);
    expect_lk("sat", 1'b0, 22'h3, 22'h0, 1'b0);
    expect_cnt("sat", 16'd8, 16'hFFFF);

    // Put a hit on the outputs, then reset in the middle of a lookup.
    fill(32'h0000_0800, 22'h123);
    lookup(32'h0000_0800);
    expect_lk("prerst", 1'b1, 22'h2, 22'h123, 1'b0);
    lookupValid = 1'b1; virtAddrIn = 32'h0000_0800;
    #2;
    resetN = 1'b0;
    #1;
    check("arst.done", 32'(lookupDone), 32'd0);
    check("arst.hit",  32'(hit), 32'd0);
    check("arst.vpn",  32'(virtPageOut), 32'd0);
    check("arst.ppn",  32'(physPageOut), 32'd0);
    check("arst.way",  32'(hitWay), 32'd0);
    expect_cnt("arst", 16'd0, 16'd0);
    tick();
    lookupValid = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    check("rel1.done", 32'(lookupDone), 32'd0);
    tick();
    check("rel2.done", 32'(lookupDone), 32'd0);
    lookup(32'h0000_0800);
    expect_lk("postrst", 1'b0, 22'h2, 22'h0, 1'b0);
    expect_cnt("postrst", 16'd0, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Parametrised set-associative translation lookaside buffer, successor to the 16-entry direct-mapped TLB in the address translation path. It holds virtual-page to physical-page mappings with per-entry valid bits. Lookups have a fixed one-cycle registered latency. Fills use a dedicated port with invalid-first then round-robin replacement. It adds a single-cycle global flush and saturating hit/miss counters for the memory subsystem.

## Interface
- VA_WIDTH, 32, virtual address width
- OFFSET_BITS, 10, page offset width; VPN width = VA_WIDTH-OFFSET_BITS
- PPN_WIDTH, 22, physical page number width
- SET_BITS, 2, log2 of set count (4 sets)
- WAYS, 2, associativity (1..8)
- CNT_WIDTH, 16, statistics counter width
- clk  input  1  global clock, all state updates on rising edge
- resetN  input  1  asynchronous, active-low reset
- lookupValid  input  1  start lookup of virtAddrIn this cycle
- virtAddrIn  input  VA_WIDTH  lookup virtual address
- fillValid  input  1  write mapping this cycle
- fillVirtAddr  input  VA_WIDTH  fill virtual address (offset bits ignored)
- fillPhysPage  input  PPN_WIDTH  fill physical page number
- flush  input  1  invalidate all entries
- lookupDone  output  1  one-cycle pulse, lookup result valid
- hit  output  1  lookup matched a valid entry
- virtPageOut  output  VA_WIDTH-OFFSET_BITS  VPN of the looked-up address
- physPageOut  output  PPN_WIDTH  matched PPN; 0 on miss
- hitWay  output  $clog2(WAYS) (min 1)  matching way; 0 on miss
- hitCount, missCount  output  CNT_WIDTH  saturating statistics

## Operation
- Set index = VPN[SET_BITS-1:0]. The tag stores the full VPN. An entry is valid bit + VPN + PPN.
- Lookup: compare the VPN against all valid ways of the indexed set.
  - At most one way matches, guaranteed by the fill rule below.
  - Results register on the next edge.
- Fill:
  - If the VPN already resides valid in the set, overwrite that way's PPN. The replacement pointer does not change.
  - Otherwise write the lowest-numbered invalid way. The pointer does not change.
  - Otherwise write the way given by the set's round-robin pointer, then increment the pointer modulo WAYS.
- Flush clears every valid bit in one cycle. PPN/VPN storage, pointers and counters are untouched.
- Same-cycle events:
  - Lookup evaluates against state before any update that cycle.
  - Flush with lookup forces hit=0 for that lookup.
  - Flush with fill: flush wins, the fill is dropped, and all entries end invalid.
- Counters: each completed lookup increments hitCount or missCount. Counters saturate at all-ones. No wrap.

## Timing
- Lookup latency is 1 cycle. lookupValid at edge N gives lookupDone=1 and stable results after edge N+1.
- hit, virtPageOut, physPageOut and hitWay hold until the next lookupDone.
- Back-to-back lookups are accepted every cycle. There is no stall and no busy signal.
- A fill at edge N is visible to a lookup issued at edge N+1.
- Reset (asynchronous, immediate, mid-operation included) forces the following to 0:
  - all outputs
  - all valid bits
  - all round-robin pointers
  - both counters

  An in-flight lookup is discarded, and there is no lookupDone after reset release.

## Test plan
- Reset, then lookup 0x0000_1400 -> next cycle lookupDone=1, hit=0, physPageOut=0, virtPageOut=0x5, missCount=1.
- Fill 0x0000_1400 / PPN 0x3A, then lookup 0x0000_17FF -> hit=1, physPageOut=0x3A, hitWay=0, hitCount=1.
- Set 1 replacement:
  - Stimulus: fill VPN 0x5 (PPN 0x10), 0x9 (0x20), 0xD (0x30).
  - Expected placement: 0x5 in way 0, 0x9 in way 1, 0xD replaces way 0 and the pointer becomes 1.
  - Lookups: 0x1400 misses, 0x2400 hits way 1 (0x20), 0x3400 hits way 0 (0x30).
- Refill VPN 0x9 with PPN 0x77 -> way 1 overwritten and pointer stays 1. Lookup 0x2400 gives hit=1, physPageOut=0x77, and no duplicate entry.
- Flush in the same cycle as a lookup of a resident VPN, plus a fill -> that lookup gives hit=0. All later lookups miss, counters are unaffected by the flush, and the fill is absent.
- Force missCount to 0xFFFF, then do one more miss -> it stays 0xFFFF. Assert resetN low mid-lookup -> all outputs are 0 immediately, and no lookupDone follows.
